// File: rtl/rv32i_fetch_unit.sv
// Instruction fetch stage: one outstanding word read per PC, stale-response
// discard on redirect, and error pulses for misaligned PCs or memory timeouts.
module rv32i_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] instruction_code,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_req_addr, w_req_addr_nxt;
    logic [TW-1:0]   r_tcnt, w_tcnt_nxt;
    logic [31:0]     w_instr_nxt, w_addr_nxt;
    logic            w_valid_nxt, w_req_nxt, w_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_req_addr_nxt = r_req_addr;
        w_tcnt_nxt     = r_tcnt;
        w_instr_nxt    = instruction_code;
        w_valid_nxt    = instr_valid;
        w_addr_nxt     = imem_addr;
        w_req_nxt      = 1'b0;
        w_err_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pc[1:0] != 2'b00) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_req_nxt      = 1'b1;
                    w_addr_nxt     = pc;
                    w_req_addr_nxt = pc;
                    w_tcnt_nxt     = '0;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                w_tcnt_nxt = r_tcnt + 1'b1;
                // A response coinciding with the timeout cycle wins over the error.
                if (imem_rvalid) begin
                    if (pc == r_req_addr) begin
                        w_instr_nxt = imem_rdata;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_tcnt == TW'(TIMEOUT)) begin
                    w_err_nxt   = 1'b1;
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready || pc != r_req_addr) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_addr       <= '0;
            r_tcnt           <= '0;
            instruction_code <= NOP_INSTR;
            instr_valid      <= 1'b0;
            imem_req         <= 1'b0;
            imem_addr        <= '0;
            fetch_err        <= 1'b0;
        end else begin
            r_req_addr       <= w_req_addr_nxt;
            r_tcnt           <= w_tcnt_nxt;
            instruction_code <= w_instr_nxt;
            instr_valid      <= w_valid_nxt;
            imem_req         <= w_req_nxt;
            imem_addr        <= w_addr_nxt;
            fetch_err        <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Scoreboard bench for rv32i_fetch_unit: directed PC sequences with a simple
// latency-programmable memory responder; a monitor checks every DUT event.
module tb_rv32i_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] instruction_code;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_req[$];
    logic [31:0] q_ins[$];
    int          q_err[$];

    bit mem_auto = 1'b0;
    int mem_lat  = 1;

    rv32i_fetch_unit #(.NOP_INSTR(32'h0000_0013), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .instruction_code(instruction_code), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00: return 32'h0050_0093;
            32'h04: return 32'h0010_0113;
            32'h08: return 32'h0020_81b3;
            32'h10: return 32'hdead_beef;
            32'h40: return 32'h00c0_0293;
            default: return 32'h1357_2468;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: instr_valid got 0 for 40 cycles, expected 1", nm);
        end
    endtask

    // Fetch one word with instr_ready held high; the core steps pc right after consume.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        q_req.push_back(a);
        q_ins.push_back(d);
        pc = a;
        wait_valid("fetch_valid");
        tick();
    endtask

    // Memory responder: answers each request mem_lat cycles later.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (imem_req && mem_auto && !rst) begin
                a = imem_addr;
                repeat (mem_lat) @(posedge clk);
                #1;
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(a);
                @(posedge clk);
                #1;
                imem_rvalid = 1'b0;
            end
        end
    end

    // Monitor: every request, error pulse and new instruction is matched to the scoreboard.
    initial begin
        int  cyc = 0;
        int  req_cyc = 0;
        int  e;
        bit  prev_v = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (imem_req) begin
                    req_cyc = cyc;
                    if (q_req.size() == 0) chk("unexpected_req", imem_addr, 32'hffff_ffff);
                    else chk("req_addr", imem_addr, q_req.pop_front());
                end
                if (fetch_err) begin
                    if (q_err.size() == 0) chk("unexpected_err", 32'(fetch_err), 32'd0);
                    else begin
                        e = q_err.pop_front();
                        if (e >= 0) chk("err_delay", 32'(cyc - req_cyc), 32'(e));
                    end
                end
                if (instr_valid && !prev_v) begin
                    if (q_ins.size() == 0) chk("unexpected_valid", instruction_code, 32'hffff_ffff);
                    else chk("instr_code", instruction_code, q_ins.pop_front());
                end
            end
            prev_v = instr_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation got no end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        repeat (3) tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_code", instruction_code, 32'h13);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);

        // Best-case latency and hold-until-ready
        q_req.push_back(32'h0);
        q_ins.push_back(32'h0050_0093);
        mem_lat = 1; mem_auto = 1'b1;
        rst = 1'b0;
        tick();
        chk("t1_req_hi", 32'(imem_req), 32'd1);
        tick();
        chk("t1_req_lo", 32'(imem_req), 32'd0);
        chk("t1_not_yet", 32'(instr_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(instr_valid), 32'd1);
        repeat (4) tick();
        chk("t1_hold_valid", 32'(instr_valid), 32'd1);
        chk("t1_hold_code", instruction_code, 32'h0050_0093);
        instr_ready = 1'b1;
        tick();
        chk("t1_consumed", 32'(instr_valid), 32'd0);

        // Sequential stream, 3-cycle memory
        mem_lat = 3;
        fetch(32'h0, 32'h0050_0093);
        fetch(32'h4, 32'h0010_0113);
        fetch(32'h8, 32'h0020_81b3);

        // Redirect while waiting: 0x10 response is dropped, 0x40 refetched
        q_req.push_back(32'h10);
        q_req.push_back(32'h40);
        q_ins.push_back(32'h00c0_0293);
        pc = 32'h10;
        tick();
        chk("rd_addr", imem_addr, 32'h10);
        pc = 32'h40;
        wait_valid("rd_valid");
        chk("rd_code", instruction_code, 32'h00c0_0293);
        tick();

        // Misaligned pc: one error per IDLE cycle, no requests
        repeat (4) q_err.push_back(-1);
        pc = 32'h6;
        repeat (4) begin
            tick();
            chk("mis_err", 32'(fetch_err), 32'd1);
            chk("mis_noreq", 32'(imem_req), 32'd0);
        end
        mem_lat = 1;
        fetch(32'h8, 32'h0020_81b3);

        // Timeout with no response, then a late response in HOLD
        mem_auto = 1'b0;
        instr_ready = 1'b0;
        q_req.push_back(32'h20);
        q_err.push_back(5);
        q_ins.push_back(32'h13);
        pc = 32'h20;
        wait_valid("to_valid");
        chk("to_code", instruction_code, 32'h13);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hbad0_bad0;
        tick();
        imem_rvalid = 1'b0;
        tick();
        chk("to_late_valid", 32'(instr_valid), 32'd1);
        chk("to_late_code", instruction_code, 32'h13);
        chk("to_single_err", 32'(fetch_err), 32'd0);
        instr_ready = 1'b1;
        tick();

        // Reset mid-WAIT, response delivered during reset, fetch restarts
        q_req.push_back(32'h30);
        pc = 32'h30;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(instr_valid), 32'd0);
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hbad0_bad0;
        tick();
        imem_rvalid = 1'b0;
        chk("mr_code", instruction_code, 32'h13);
        chk("mr_err", 32'(fetch_err), 32'd0);
        q_req.push_back(32'h30);
        q_ins.push_back(32'h1357_2468);
        mem_lat = 1; mem_auto = 1'b1;
        rst = 1'b0;
        wait_valid("mr_restart");
        chk("mr_restart_code", instruction_code, 32'h1357_2468);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        chk("q_req_empty", 32'(q_req.size()), 32'd0);
        chk("q_ins_empty", 32'(q_ins.size()), 32'd0);
        chk("q_err_empty", 32'(q_err.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
